// File: rtl/hit_manager.sv
// rtl/hit_manager.sv - collision-to-life-loss sequencer with respawn freeze and invulnerability timing
// One clean game_stop per hit, clear on start, and a phase counter shared by the timed states.
module hit_manager #(
  parameter int RESPAWN_CYCLES = 50_000_000,
  parameter int INVULN_CYCLES  = 100_000_000,
  parameter int CNT_W          = 27,
  parameter int BLINK_BIT      = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       collision,
  input  logic       game_end,
  output logic       game_stop,
  output logic       clear,
  output logic       freeze,
  output logic       invincible,
  output logic       sprite_on,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_HIT     = 3'd2,
    S_RESPAWN = 3'd3,
    S_INVULN  = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] INV_LAST  = CNT_W'(INVULN_CYCLES - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             game_stop_d, game_stop_q;
  logic             clear_d, clear_q;
  logic             freeze_d, freeze_q;
  logic             invincible_d, invincible_q;
  logic             sprite_on_d, sprite_on_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    game_stop_d = 1'b0;
    clear_d     = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          clear_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (collision) begin
          state_d     = S_HIT;
          game_stop_d = 1'b1;
        end
      end
      // life has had a full cycle to react to game_stop before game_end is used here
      S_HIT: state_d = game_end ? S_OVER : S_RESPAWN;
      S_RESPAWN: begin
        if (cnt_q == RESP_LAST) state_d = S_INVULN;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_INVULN: begin
        if (cnt_q == INV_LAST) state_d = S_PLAY;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so the registered copies track state_q exactly
    freeze_d     = !((state_d == S_PLAY) || (state_d == S_INVULN));
    invincible_d = (state_d == S_RESPAWN) || (state_d == S_INVULN);
    sprite_on_d  = (state_d == S_INVULN) ? ~cnt_d[BLINK_BIT] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      game_stop_q  <= 1'b0;
      clear_q      <= 1'b0;
      freeze_q     <= 1'b1;
      invincible_q <= 1'b0;
      sprite_on_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      game_stop_q  <= game_stop_d;
      clear_q      <= clear_d;
      freeze_q     <= freeze_d;
      invincible_q <= invincible_d;
      sprite_on_q  <= sprite_on_d;
    end
  end

  assign state      = state_q;
  assign game_stop  = game_stop_q;
  assign clear      = clear_q;
  assign freeze     = freeze_q;
  assign invincible = invincible_q;
  assign sprite_on  = sprite_on_q;

endmodule

// File: tb/tb_hit_manager.sv
// tb/tb_hit_manager.sv - self-checking bench for hit_manager with a behavioural life counter
module tb_hit_manager;

  localparam int R  = 4;
  localparam int I  = 8;
  localparam int CW = 4;
  localparam int B  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       game_end;
  logic       game_stop, clear, freeze, invincible, sprite_on;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int lives = 3;

  hit_manager #(
    .RESPAWN_CYCLES(R),
    .INVULN_CYCLES (I),
    .CNT_W         (CW),
    .BLINK_BIT     (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .collision (collision),
    .game_end  (game_end),
    .game_stop (game_stop),
    .clear     (clear),
    .freeze    (freeze),
    .invincible(invincible),
    .sprite_on (sprite_on),
    .state     (state)
  );

  always #5 clk = ~clk;

  // life counter: reloads on clear, decrements on each game_stop rising edge
  always @(posedge clear or posedge game_stop) begin
    if (clear) lives = 3;
    else if (lives > 0) lives = lives - 1;
  end
  assign game_end = (lives == 0);

  typedef struct {
    logic       s;
    logic       c;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [7:0] pk(input int st, input bit clr, input bit stp,
                                    input bit frz, input bit inv, input bit spr);
    logic [2:0] s3;
    s3 = st[2:0];
    return {s3, clr, stp, frz, inv, spr};
  endfunction

  function automatic vec_t mk(input bit s, input bit c, input logic [7:0] e);
    vec_t v;
    v.s = s; v.c = c; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {state, clear, game_stop, freeze, invincible, sprite_on};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // reference model: position within a hit sequence measured as cycles since the hit
  bit m_run, m_lost;
  int m_age;

  task automatic model_reset();
    m_run = 0; m_lost = 0; m_age = -1;
  endtask

  task automatic model_step(input bit s, input bit c, input bit ge, output logic [7:0] e);
    bit clr, stp, frz, inv, spr;
    int st;
    clr = 0; stp = 0;
    if (!m_run) begin
      if (s) begin m_run = 1; clr = 1; end
    end else if (m_age < 0) begin
      if (c) begin m_age = 0; stp = 1; end
    end else if (m_age == 0) begin
      if (ge) begin m_run = 0; m_lost = 1; m_age = -1; end
      else m_age = 1;
    end else if (m_age < R + I) begin
      m_age++;
    end else begin
      m_age = -1;
    end
    if (!m_run)           st = m_lost ? 5 : 0;
    else if (m_age < 0)   st = 1;
    else if (m_age == 0)  st = 2;
    else if (m_age <= R)  st = 3;
    else                  st = 4;
    frz = !m_run || (m_age >= 0 && m_age <= R);
    inv = m_run && m_age >= 1;
    spr = !(m_run && m_age > R) || (((m_age - R - 1) >> B) & 1) == 0;
    e = pk(st, clr, stp, frz, inv, spr);
  endtask

  initial begin
    int pulses[$];
    logic [7:0] e;
    bit ge, ok;

    tbl[0]  = mk(0, 1, pk(0, 0, 0, 1, 0, 1));
    tbl[1]  = mk(1, 0, pk(1, 1, 0, 0, 0, 1));
    tbl[2]  = mk(1, 0, pk(1, 0, 0, 0, 0, 1));
    tbl[3]  = mk(1, 0, pk(1, 0, 0, 0, 0, 1));
    tbl[4]  = mk(0, 1, pk(2, 0, 1, 1, 0, 1));
    tbl[5]  = mk(0, 1, pk(3, 0, 0, 1, 1, 1));
    tbl[6]  = mk(0, 1, pk(3, 0, 0, 1, 1, 1));
    tbl[7]  = mk(0, 1, pk(3, 0, 0, 1, 1, 1));
    tbl[8]  = mk(0, 1, pk(3, 0, 0, 1, 1, 1));
    tbl[9]  = mk(0, 0, pk(4, 0, 0, 0, 1, 1));
    tbl[10] = mk(0, 1, pk(4, 0, 0, 0, 1, 1));
    tbl[11] = mk(0, 0, pk(4, 0, 0, 0, 1, 0));
    tbl[12] = mk(0, 1, pk(4, 0, 0, 0, 1, 0));
    tbl[13] = mk(0, 0, pk(4, 0, 0, 0, 1, 1));
    tbl[14] = mk(0, 1, pk(4, 0, 0, 0, 1, 1));
    tbl[15] = mk(0, 0, pk(4, 0, 0, 0, 1, 0));
    tbl[16] = mk(0, 0, pk(4, 0, 0, 0, 1, 0));
    tbl[17] = mk(0, 0, pk(1, 0, 0, 0, 0, 1));
    tbl[18] = mk(0, 0, pk(1, 0, 0, 0, 0, 1));

    repeat (3) tick();
    chk("reset_state", 32'(outs()), 32'(pk(0, 0, 0, 1, 0, 1)));
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(outs()), 32'(pk(0, 0, 0, 1, 0, 1)));

    foreach (tbl[k]) begin
      start = tbl[k].s;
      collision = tbl[k].c;
      tick();
      chk($sformatf("vec%0d", k), 32'(outs()), 32'(tbl[k].exp));
    end
    chk("lives_after_one_hit", 32'(lives), 32'd2);

    // continuous collision until game over
    rst_n = 1'b0; start = 0; collision = 0;
    tick();
    rst_n = 1'b1;
    start = 1; tick(); start = 0;
    chk("lives_after_start", 32'(lives), 32'd3);
    collision = 1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      tick();
      if (game_stop) pulses.push_back(cyc);
    end
    chk("pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("pulse_gap1", 32'(pulses[1] - pulses[0]), 32'd14);
      chk("pulse_gap2", 32'(pulses[2] - pulses[1]), 32'd14);
    end
    chk("over_state", 32'(state), 32'd5);
    chk("over_freeze", 32'(freeze), 32'd1);
    chk("over_lives", 32'(lives), 32'd0);

    // restart from OVER, then an immediate hit
    collision = 0; start = 1;
    tick();
    chk("restart_clear", 32'({clear, game_stop, state}), 32'({1'b1, 1'b0, 3'd1}));
    chk("restart_lives", 32'(lives), 32'd3);
    start = 0; collision = 1;
    tick();
    chk("hit_after_clear", 32'({clear, game_stop, state}), 32'({1'b0, 1'b1, 3'd2}));
    collision = 0;
    tick();
    tick();
    chk("in_respawn", 32'(state), 32'd3);

    // asynchronous reset in the middle of RESPAWN
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({state, invincible, freeze}), 32'({3'd0, 1'b0, 1'b1}));
    tick();
    rst_n = 1'b1;
    collision = 1;
    ok = 1;
    repeat (5) begin
      tick();
      if (state != 3'd0 || game_stop) ok = 0;
    end
    chk("coll_ignored_idle", 32'(ok), 32'd1);
    collision = 0; start = 1;
    tick();
    chk("start_after_reset", 32'({clear, state}), 32'({1'b1, 3'd1}));
    start = 0;

    // randomized run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        start = 0; collision = 0;
        tick();
        model_reset();
        chk("rand_reset", 32'(outs()), 32'(pk(0, 0, 0, 1, 0, 1)));
        rst_n = 1'b1;
      end else begin
        start = ($urandom_range(0, 15) == 0);
        collision = ($urandom_range(0, 2) == 0);
        ge = game_end;
        tick();
        model_step(start, collision, ge, e);
        chk($sformatf("rand%0d", n), 32'(outs()), 32'(e));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
